// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic intersection controller.
// Macro TRAFFIC_PED_EN adds the pedestrian walk state to the state enum.
package traffic_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        ALLRED_N,
        NS_GREEN,
        NS_YELLOW,
        ALLRED_E,
        EW_GREEN,
        EW_YELLOW
`ifdef TRAFFIC_PED_EN
        ,
        PED_WALK
`endif
    } state_t;

    typedef enum logic {
        DIR_NS,
        DIR_EW
    } dir_t;

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter for phase timing; sticks at zero until reloaded.
// Reset value is a parameter so the power-on phase is already timed.
module phase_timer #(
    parameter int               W         = 8,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: NS main road rests green, EW side road on demand.
// Define TRAFFIC_PED_EN to add the pedestrian walk phase between all-red and green.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_done;
    logic                w_ped_pend_eff;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = CNT_W'(T_GREEN - 1);
            NS_YELLOW, EW_YELLOW: phase_len = CNT_W'(T_YELLOW - 1);
`ifdef TRAFFIC_PED_EN
            PED_WALK:             phase_len = CNT_W'(T_WALK - 1);
`endif
            default:              phase_len = CNT_W'(T_ALLRED - 1);
        endcase
    endfunction

    phase_timer #(
        .W         (CNT_W),
        .RESET_VAL (CNT_W'(T_ALLRED - 1))
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

`ifdef TRAFFIC_PED_EN
    logic r_ped_pend;
    dir_t r_next_dir;

    // A request arriving on the deciding cycle already counts as pending.
    assign w_ped_pend_eff = r_ped_pend | (ped_req & (r_state != PED_WALK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ped_pend <= 1'b0;
            r_next_dir <= DIR_NS;
        end else begin
            if (w_state_next == PED_WALK && r_state != PED_WALK) begin
                r_ped_pend <= 1'b0;
            end else begin
                r_ped_pend <= w_ped_pend_eff;
            end
            if (r_state == ALLRED_E) begin
                r_next_dir <= DIR_EW;
            end else if (r_state == ALLRED_N) begin
                r_next_dir <= DIR_NS;
            end
        end
    end
`else
    logic w_unused_ped;
    assign w_unused_ped   = ped_req;
    assign w_ped_pend_eff = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ALLRED_N;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ALLRED_N: begin
                if (w_done) begin
                    w_state_next = NS_GREEN;
`ifdef TRAFFIC_PED_EN
                    if (w_ped_pend_eff) w_state_next = PED_WALK;
`endif
                end
            end
            NS_GREEN: begin
                if (w_done && (ew_car || w_ped_pend_eff)) w_state_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (w_done) w_state_next = ALLRED_E;
            end
            ALLRED_E: begin
                if (w_done) begin
                    w_state_next = EW_GREEN;
`ifdef TRAFFIC_PED_EN
                    if (w_ped_pend_eff) w_state_next = PED_WALK;
`endif
                end
            end
            EW_GREEN: begin
                if (w_done) w_state_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (w_done) w_state_next = ALLRED_N;
            end
`ifdef TRAFFIC_PED_EN
            PED_WALK: begin
                if (w_done) w_state_next = (r_next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
            end
`endif
            default: w_state_next = ALLRED_N;
        endcase
    end

    assign w_load     = (w_state_next != r_state);
    assign w_load_val = phase_len(w_state_next);

    // Lamps depend on the state register alone, so inputs never reach outputs combinationally.
    always_comb begin
        light_ns = LAMP_RED;
        light_ew = LAMP_RED;
        walk     = 1'b0;
        case (r_state)
            NS_GREEN:  light_ns = LAMP_GREEN;
            NS_YELLOW: light_ns = LAMP_YELLOW;
            EW_GREEN:  light_ew = LAMP_GREEN;
            EW_YELLOW: light_ew = LAMP_YELLOW;
`ifdef TRAFFIC_PED_EN
            PED_WALK:  walk     = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl: directed timelines plus a
// randomized run against a phase/age reference model. Honours TRAFFIC_PED_EN.
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam int P_AR_N = 0, P_NG = 1, P_NY = 2, P_AR_E = 3, P_EG = 4, P_EY = 5, P_WALK = 6;

    logic       clk;
    logic       reset_n;
    logic       ew_car;
    logic       ped_req;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic       walk;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_age;
    int m_resume;
    bit m_pend;

    traffic_intersection_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .light_ns (light_ns),
        .light_ew (light_ew),
        .walk     (walk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dur(input int p);
        case (p)
            P_NG, P_EG: return 10;
            P_NY, P_EY: return 3;
            P_WALK:     return 6;
            default:    return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_phase  = P_AR_N;
        m_age    = 0;
        m_resume = P_NG;
        m_pend   = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs seen at that edge.
    task automatic model_edge(input bit ew, input bit pd);
        bit pe;
        bit expired;
        int nxt;
        pe      = m_pend | (PED && pd && m_phase != P_WALK);
        expired = (m_age + 1 >= dur(m_phase));
        nxt     = m_phase;
        if (expired) begin
            case (m_phase)
                P_AR_N: if (pe) begin nxt = P_WALK; m_resume = P_NG; end else nxt = P_NG;
                P_AR_E: if (pe) begin nxt = P_WALK; m_resume = P_EG; end else nxt = P_EG;
                P_NG:   if (ew || pe) nxt = P_NY;
                P_NY:   nxt = P_AR_E;
                P_EG:   nxt = P_EY;
                P_EY:   nxt = P_AR_N;
                P_WALK: nxt = m_resume;
                default: nxt = P_AR_N;
            endcase
        end
        m_pend  = (nxt == P_WALK && m_phase != P_WALK) ? 1'b0 : pe;
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    function automatic logic [2:0] m_ns();
        return (m_phase == P_NG) ? G : (m_phase == P_NY) ? Y : R;
    endfunction

    function automatic logic [2:0] m_ew();
        return (m_phase == P_EG) ? G : (m_phase == P_EY) ? Y : R;
    endfunction

    task automatic step(input bit ew, input bit pd);
        ew_car  = ew;
        ped_req = pd;
        @(posedge clk);
        model_edge(ew, pd);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int k, input logic [2:0] ens,
                       input logic [2:0] eew, input logic ewk);
        checks++;
        assert (light_ns === ens) else begin
            errors++;
            $error("FAIL %s cycle %0d light_ns=%b expected %b", tag, k, light_ns, ens);
        end
        checks++;
        assert (light_ew === eew) else begin
            errors++;
            $error("FAIL %s cycle %0d light_ew=%b expected %b", tag, k, light_ew, eew);
        end
        checks++;
        assert (walk === ewk) else begin
            errors++;
            $error("FAIL %s cycle %0d walk=%b expected %b", tag, k, walk, ewk);
        end
    endtask

    task automatic chk_model(input string tag, input int k);
        chk(tag, k, m_ns(), m_ew(), logic'(m_phase == P_WALK));
        checks++;
        assert ($onehot(light_ns) && $onehot(light_ew) && (light_ns === R || light_ew === R)) else begin
            errors++;
            $error("FAIL %s_safety cycle %0d ns=%b ew=%b expected one-hot with one side red",
                   tag, k, light_ns, light_ew);
        end
    endtask

    task automatic begin_run();
        reset_n = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold", 0, R, R, 1'b0);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] ens, eew;
        logic       ewk;
        bit         ew, pd;

        reset_n = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;

        // Idle intersection: NS rests green indefinitely.
        begin_run();
        for (int k = 0; k <= 100; k++) begin
            chk("idle", k, (k < 2) ? R : G, R, 1'b0);
            chk_model("idle_model", k);
            step(1'b0, 1'b0);
        end
        $display("run idle: NS green held to cycle 100");

        // Side-road car present from reset: full cycle.
        begin_run();
        for (int k = 0; k <= 41; k++) begin
            ens = R; eew = R;
            if (k >= 2 && k < 12) ens = G;
            else if (k >= 12 && k < 15) ens = Y;
            else if (k >= 17 && k < 27) eew = G;
            else if (k >= 27 && k < 30) eew = Y;
            else if (k >= 32) ens = G;
            chk("ew_cycle", k, ens, eew, 1'b0);
            chk_model("ew_cycle_model", k);
            step(1'b1, 1'b0);
        end
        $display("run ew_cycle: full NS/EW rotation done");

        // Reset pulse while EW is green.
        begin_run();
        for (int k = 0; k <= 20; k++) begin
            step(1'b1, 1'b0);
        end
        chk("pre_reset_ewg", 21, R, G, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 21, R, R, 1'b0);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            chk("after_reset", k, (k < 2) ? R : G, R, 1'b0);
            step(1'b0, 1'b0);
        end
        $display("run mid_reset: restart sequence checked");

        // Pedestrian pulse at cycle 5, button held through the walk.
        begin_run();
        for (int k = 0; k <= 60; k++) begin
            ens = R; eew = R; ewk = 1'b0;
            if (PED) begin
                if (k >= 2 && k < 12) ens = G;
                else if (k >= 12 && k < 15) ens = Y;
                else if (k >= 17 && k < 23) ewk = 1'b1;
                else if (k >= 23 && k < 33) eew = G;
                else if (k >= 33 && k < 36) eew = Y;
                else if (k >= 38) ens = G;
            end else if (k >= 2) begin
                ens = G;
            end
            chk("ped", k, ens, eew, ewk);
            chk_model("ped_model", k);
            step(1'b0, (k == 5) || (k >= 17 && k <= 22));
        end
        $display("run ped: walk phase sequence checked");

        // Randomized traffic against the reference model.
        begin_run();
        for (int k = 0; k < 3000; k++) begin
            chk_model("random", k);
            ew = ($urandom_range(0, 5) == 0);
            pd = ($urandom_range(0, 11) == 0);
            step(ew, pd);
        end
        $display("run random: 3000 cycles compared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter T_GREEN, default 10, minimum green duration in cycles (range 1..255).
REQ-002 SHALL have parameter T_YELLOW, default 3, yellow duration in cycles (range 1..255).
REQ-003 SHALL have parameter T_ALLRED, default 2, all-red clearance duration in cycles (range 1..255).
REQ-004 SHALL have parameter T_WALK, default 6, pedestrian walk duration in cycles (range 1..255).
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ew_car, input, 1, side-road (EW) vehicle present; synchronous to clk.
REQ-008 SHALL have port ped_req, input, 1, pedestrian button; synchronous to clk; level sampled each cycle.
REQ-009 SHALL have port light_ns, output, 3, NS lamp {red, yellow, green}; one-hot.
REQ-010 SHALL have port light_ew, output, 3, EW lamp {red, yellow, green}; one-hot.
REQ-011 SHALL have port walk, output, 1, pedestrian walk lamp.

Function
REQ-012 SHALL implement states ALLRED_N, NS_GREEN, NS_YELLOW, ALLRED_E, EW_GREEN, EW_YELLOW, PED_WALK.
REQ-013 SHALL decode all outputs from the state register only; no combinational input-to-output path.
REQ-014 SHALL drive RED=3'b100, YELLOW=3'b010, GREEN=3'b001; the lamp of the non-active direction SHALL be RED; both RED in ALLRED_*/PED_WALK; walk=1 only in PED_WALK.
REQ-015 SHALL load the phase counter with T-1 on state entry and decrement per cycle, so each timed state lasts exactly T cycles.
REQ-016 NS_GREEN: when counter==0 and (ew_car or ped_pend), SHALL go to NS_YELLOW; otherwise SHALL hold NS_GREEN with counter held at 0 (indefinite extension).
REQ-017 NS_YELLOW->ALLRED_E after T_YELLOW; EW_GREEN->EW_YELLOW after T_GREEN unconditionally; EW_YELLOW->ALLRED_N after T_YELLOW.
REQ-018 ALLRED_E SHALL go to PED_WALK if ped_pend, else to EW_GREEN; ALLRED_N SHALL go to PED_WALK if ped_pend, else to NS_GREEN.
REQ-019 PED_WALK SHALL last T_WALK cycles, then enter the green that the preceding all-red would have entered (1-bit next_dir register).
REQ-020 ped_pend SHALL set on any cycle with ped_req=1 outside PED_WALK, SHALL clear on entry to PED_WALK; ped_req during PED_WALK SHALL be ignored.
REQ-021 ped_req and the counter reaching 0 on the same cycle SHALL count as pending (set wins for the transition decision).
REQ-022 No state SHALL ever drive GREEN or YELLOW on both directions simultaneously.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state ALLRED_N, counter T_ALLRED-1, ped_pend=0, next_dir=NS, light_ns=light_ew=3'b100, walk=0.
REQ-024 Reset asserted mid-phase SHALL abandon the phase immediately; no partial timing retained.

Configuration
REQ-025 With TRAFFIC_PED_EN defined, the pedestrian logic SHALL be present as in REQ-018..REQ-021.
REQ-026 Without TRAFFIC_PED_EN, PED_WALK, ped_pend and next_dir SHALL be absent; ped_req SHALL be ignored; walk SHALL be constant 0; NS_GREEN SHALL leave only on ew_car.

Structure
REQ-027 A shared package traffic_pkg SHALL hold the state enum typedef, the RED/YELLOW/GREEN lamp constants and the counter width (8).
REQ-028 A sub-module phase_timer (load, load value, done flag, hold-at-zero) SHALL implement the counter.

Verification (defaults; cycle 0 = first rising edge after reset release)
REQ-029 Reset release, ew_car=0, ped_req=0 -> both RED cycles 0-1; NS GREEN from cycle 2 and held indefinitely (checked to cycle 100).
REQ-030 ew_car=1 from reset -> NS GREEN 2-11, NS YELLOW 12-14, all-red 15-16, EW GREEN 17-26, EW YELLOW 27-29, all-red 30-31, NS GREEN 32.
REQ-031 TRAFFIC_PED_EN, ped_req pulse 1 cycle at cycle 5, ew_car=0 -> NS YELLOW 12-14, all-red 15-16, walk=1 cycles 17-22, EW GREEN 23.
REQ-032 ped_req held high during PED_WALK -> no second walk phase afterwards; ped_pend=0 at exit.
REQ-033 reset_n pulsed low during EW_GREEN -> outputs both RED, walk=0 within the same cycle, sequence restarts per REQ-029.
REQ-034 Every cycle of all runs -> lamps one-hot, never GREEN/YELLOW on both directions; without TRAFFIC_PED_EN walk stays 0 under ped_req toggling.
